// File: rtl/psram_qpi_responder.sv
// Device-side PSRAM model: decodes SPI QPI-enable, then QPI quad write (0x38) and
// quad fast read (0xEB) against an internal byte RAM, oversampling the serial clock.
module psram_qpi_responder #(
   parameter int          ADDR_WIDTH   = 12,
   parameter int          WAIT_CYCLES  = 6,
   parameter logic [7:0]  CMD_QPI_EN   = 8'h35,
   parameter logic [7:0]  CMD_QPI_EXIT = 8'hF5,
   parameter logic [7:0]  CMD_WRITE    = 8'h38,
   parameter logic [7:0]  CMD_READ     = 8'hEB
) (
   input  logic       i_clkRAM,
   input  logic       reset,
   input  logic       i_psram_sclk,
   input  logic       i_psram_cs,
   input  logic [3:0] i_sio,
   output logic [3:0] o_sio,
   output logic       o_sio_oe,
   output logic       o_qpiMode,
   output logic       o_busy,
   output logic       o_cmdError
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, READ, WRITE, IGNORE} state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   state_t                state_q;
   logic                  sclk_q, sclk_q2, cs_q;
   logic [3:0]            sio_q;
   logic [7:0]            shift_q, cmd_d;
   logic [3:0]            cnt_q;
   logic                  cmdLast;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  isRead_q, pendEn_q, pendExit_q, phase_q;
   logic [7:0]            waitCnt_q;
   logic [3:0]            wrHi_q;
   logic [7:0]            rdByte_q;
   logic                  sclkRise, sclkFall, memWe;
   logic [7:0]            mem [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge i_clkRAM) begin
      if (reset) begin
         sclk_q  <= 1'b0;
         sclk_q2 <= 1'b0;
         cs_q    <= 1'b1;
         sio_q   <= 4'h0;
      end else begin
         sclk_q  <= i_psram_sclk;
         sclk_q2 <= sclk_q;
         cs_q    <= i_psram_cs;
         sio_q   <= i_sio;
      end
   end

   assign sclkRise = sclk_q & ~sclk_q2;
   assign sclkFall = ~sclk_q & sclk_q2;
   assign o_busy   = (state_q != IDLE);

   // SPI mode shifts one bit per rise from SIO0; QPI mode shifts a whole nibble.
   always_comb begin
      cmd_d   = o_qpiMode ? {shift_q[3:0], sio_q} : {shift_q[6:0], sio_q[0]};
      cmdLast = o_qpiMode ? (cnt_q == 4'd1) : (cnt_q == 4'd7);
   end

   assign memWe = !reset && !cs_q && (state_q == WRITE) && sclkRise && phase_q;

   always_ff @(posedge i_clkRAM) begin
      if (memWe) mem[addr_q] <= {wrHi_q, sio_q};
      rdByte_q <= mem[addr_q];
   end

   // CS high (and reset) abort from any state; a pending mode change lands here.
   always_ff @(posedge i_clkRAM) begin
      o_cmdError <= 1'b0;
      if (reset || cs_q) begin
         state_q    <= IDLE;
         o_sio_oe   <= 1'b0;
         o_sio      <= 4'h0;
         shift_q    <= 8'h00;
         cnt_q      <= 4'd0;
         waitCnt_q  <= 8'd0;
         phase_q    <= 1'b0;
         pendEn_q   <= 1'b0;
         pendExit_q <= 1'b0;
         if (reset) begin
            o_qpiMode <= 1'b0;
            addr_q    <= '0;
            isRead_q  <= 1'b0;
            wrHi_q    <= 4'h0;
         end else if (pendEn_q) begin
            o_qpiMode <= 1'b1;
         end else if (pendExit_q) begin
            o_qpiMode <= 1'b0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= CMD;
               shift_q <= 8'h00;
               cnt_q   <= 4'd0;
            end
            CMD: if (sclkRise) begin
               shift_q <= cmd_d;
               cnt_q   <= cnt_q + 4'd1;
               if (cmdLast) begin
                  cnt_q   <= 4'd0;
                  state_q <= IGNORE;
                  if (!o_qpiMode) begin
                     if (cmd_d == CMD_QPI_EN) pendEn_q <= 1'b1;
                     else o_cmdError <= 1'b1;
                  end else if (cmd_d == CMD_WRITE || cmd_d == CMD_READ) begin
                     state_q  <= ADDR;
                     isRead_q <= (cmd_d == CMD_READ);
                  end else if (cmd_d == CMD_QPI_EXIT) begin
                     pendExit_q <= 1'b1;
                  end else begin
                     o_cmdError <= 1'b1;
                  end
               end
            end
            ADDR: if (sclkRise) begin
               addr_q <= {addr_q[ADDR_WIDTH-5:0], sio_q};
               cnt_q  <= cnt_q + 4'd1;
               if (cnt_q == 4'd5) begin
                  cnt_q     <= 4'd0;
                  waitCnt_q <= 8'd0;
                  phase_q   <= 1'b0;
                  state_q   <= isRead_q ? WAIT : WRITE;
               end
            end
            WAIT: if (sclkRise) begin
               if (waitCnt_q == 8'(WAIT_CYCLES - 1)) begin
                  state_q <= READ;
                  phase_q <= 1'b0;
               end else begin
                  waitCnt_q <= waitCnt_q + 8'd1;
               end
            end
            READ: if (sclkFall) begin
               o_sio_oe <= 1'b1;
               phase_q  <= ~phase_q;
               if (!phase_q) begin
                  o_sio <= rdByte_q[7:4];
               end else begin
                  o_sio  <= rdByte_q[3:0];
                  addr_q <= addr_q + ADDR_ONE;
               end
            end
            WRITE: if (sclkRise) begin
               phase_q <= ~phase_q;
               if (!phase_q) wrHi_q <= sio_q;
               else addr_q <= addr_q + ADDR_ONE;
            end
            IGNORE: ;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Self-checking bench for psram_qpi_responder: directed corner cases, a vector
// table, and randomized bursts checked against a flat byte-array memory model.
module tb_psram_qpi_responder;

   localparam int PH    = 4;
   localparam int DEPTH = 4096;
   localparam int WAITC = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sclk = 1'b0;
   logic       cs = 1'b1;
   logic [3:0] sio = 4'h0;
   logic [3:0] oSio;
   logic       oSioOe, oQpiMode, oBusy, oCmdError;

   int nChecks = 0;
   int nFails = 0;
   int errPulses = 0;
   int oeCycles = 0;

   logic [7:0] modelMem [DEPTH];
   logic [7:0] rdBytes [4];
   int         writtenQ [$];

   typedef struct {
      logic [23:0] wAddr;
      logic [7:0]  wData;
      logic [23:0] rAddr;
      logic [7:0]  expData;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   psram_qpi_responder dut (
      .i_clkRAM    (clk),
      .reset       (reset),
      .i_psram_sclk(sclk),
      .i_psram_cs  (cs),
      .i_sio       (sio),
      .o_sio       (oSio),
      .o_sio_oe    (oSioOe),
      .o_qpiMode   (oQpiMode),
      .o_busy      (oBusy),
      .o_cmdError  (oCmdError)
   );

   // Count error-pulse cycles and any cycle with SIO driven.
   always @(negedge clk) begin
      if (oCmdError === 1'b1) errPulses++;
      if (oSioOe === 1'b1) oeCycles++;
   end

   initial begin
      #400_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic sclkCycle(input logic [3:0] n);
      sio  = n;
      sclk = 1'b0;
      repeat (PH) @(negedge clk);
      sclk = 1'b1;
      repeat (PH) @(negedge clk);
   endtask

   task automatic csLow();
      cs = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic csHigh(input bit chk);
      sclk = 1'b0;
      cs   = 1'b1;
      repeat (2) @(negedge clk);
      if (chk) begin
         checkOutput("busyDropAfterCs", 32'(oBusy), 32'd0);
         checkOutput("oeDropAfterCs", 32'(oSioOe), 32'd0);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic spiByte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) sclkCycle({3'($urandom), b[i]});
   endtask

   task automatic qpiByte(input logic [7:0] b);
      sclkCycle(b[7:4]);
      sclkCycle(b[3:0]);
   endtask

   task automatic qpiAddr(input logic [23:0] a);
      qpiByte(a[23:16]);
      qpiByte(a[15:8]);
      qpiByte(a[7:0]);
   endtask

   // Bytes are taken LSB-first from data; the model only ever sees whole bytes.
   task automatic applyStimulus(input logic [23:0] addr, input logic [31:0] data, input int len);
      int idx;
      csLow();
      qpiByte(8'h38);
      qpiAddr(addr);
      for (int i = 0; i < len; i++) begin
         qpiByte(data[8*i +: 8]);
         idx = (int'(addr[11:0]) + i) % DEPTH;
         modelMem[idx] = data[8*i +: 8];
         writtenQ.push_back(idx);
      end
      csHigh(1'b0);
   endtask

   task automatic qpiRead(input logic [23:0] addr, input int len, input string tag);
      int   oe0;
      int   oeBad;
      logic [3:0] hi;
      oeBad = 0;
      csLow();
      qpiByte(8'hEB);
      qpiAddr(addr);
      oe0 = oeCycles;
      for (int i = 0; i < WAITC; i++) sclkCycle(4'($urandom));
      checkOutput({tag, "_waitNoDrive"}, 32'(oeCycles - oe0), 32'd0);
      for (int i = 0; i < len; i++) begin
         for (int h = 0; h < 2; h++) begin
            sclk = 1'b0;
            repeat (PH) @(negedge clk);
            if (oSioOe !== 1'b1) oeBad++;
            if (h == 0) hi = oSio;
            else rdBytes[i] = {hi, oSio};
            sclk = 1'b1;
            repeat (PH) @(negedge clk);
         end
      end
      checkOutput({tag, "_dataOe"}, 32'(oeBad), 32'd0);
      csHigh(1'b1);
   endtask

   initial begin
      int e0, o0, idx, len;
      logic [23:0] ra;
      logic [31:0] rd;

      vecs[0] = '{24'h000010, 8'hA5, 24'hE00010, 8'hA5};
      vecs[1] = '{24'h123456, 8'h3C, 24'h000456, 8'h3C};
      vecs[2] = '{24'hFF0100, 8'h00, 24'h000100, 8'h00};
      vecs[3] = '{24'h000800, 8'hFF, 24'h5A5800, 8'hFF};
      vecs[4] = '{24'h7A0555, 8'h96, 24'h000555, 8'h96};
      vecs[5] = '{24'hABC7FF, 8'h5A, 24'h0007FF, 8'h5A};

      repeat (3) @(negedge clk);
      checkOutput("rstSio", 32'(oSio), 32'd0);
      checkOutput("rstOe", 32'(oSioOe), 32'd0);
      checkOutput("rstQpi", 32'(oQpiMode), 32'd0);
      checkOutput("rstBusy", 32'(oBusy), 32'd0);
      checkOutput("rstCmdErr", 32'(oCmdError), 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] SPI-mode write command is rejected");
      e0 = errPulses;
      csLow();
      spiByte(8'h38);
      repeat (3) @(negedge clk);
      checkOutput("spi38Err", 32'(errPulses - e0), 32'd1);
      csHigh(1'b0);
      checkOutput("spi38Qpi", 32'(oQpiMode), 32'd0);

      $display("[TB] QPI enable");
      e0 = errPulses;
      o0 = oeCycles;
      csLow();
      spiByte(8'h35);
      repeat (3) @(negedge clk);
      checkOutput("qpiEnPending", 32'(oQpiMode), 32'd0);
      csHigh(1'b0);
      checkOutput("qpiEnMode", 32'(oQpiMode), 32'd1);
      checkOutput("qpiEnErr", 32'(errPulses - e0), 32'd0);
      checkOutput("qpiEnOe", 32'(oeCycles - o0), 32'd0);

      $display("[TB] write 0xF0 then read back");
      csLow();
      qpiByte(8'h38);
      qpiAddr(24'h00AAAA);
      qpiByte(8'hF0);
      checkOutput("wrBusy", 32'(oBusy), 32'd1);
      csHigh(1'b1);
      modelMem[12'hAAA] = 8'hF0;
      qpiRead(24'h00AAAA, 1, "rdF0");
      checkOutput("rdF0Data", 32'(rdBytes[0]), 32'hF0);

      $display("[TB] burst write and read across the wrap");
      applyStimulus(24'h000FFF, 32'h2211, 2);
      qpiRead(24'h000FFF, 2, "wrap");
      checkOutput("wrapByte0", 32'(rdBytes[0]), 32'h11);
      checkOutput("wrapByte1", 32'(rdBytes[1]), 32'h22);

      $display("[TB] partial write is discarded");
      csLow();
      qpiByte(8'h38);
      qpiAddr(24'h00AAAA);
      sclkCycle(4'h5);
      csHigh(1'b1);
      qpiRead(24'h00AAAA, 1, "abort");
      checkOutput("abortData", 32'(rdBytes[0]), 32'hF0);

      $display("[TB] unknown QPI command");
      e0 = errPulses;
      o0 = oeCycles;
      csLow();
      qpiByte(8'h5A);
      sclkCycle(4'hE);
      sclkCycle(4'hB);
      csHigh(1'b0);
      checkOutput("bad5AErr", 32'(errPulses - e0), 32'd1);
      checkOutput("bad5AOe", 32'(oeCycles - o0), 32'd0);
      checkOutput("bad5AQpi", 32'(oQpiMode), 32'd1);

      $display("[TB] vector table");
      for (int v = 0; v < 6; v++) applyStimulus(vecs[v].wAddr, 32'(vecs[v].wData), 1);
      for (int v = 0; v < 6; v++) begin
         qpiRead(vecs[v].rAddr, 1, $sformatf("vec%0d", v));
         checkOutput($sformatf("vec%0dData", v), 32'(rdBytes[0]), 32'(vecs[v].expData));
      end

      $display("[TB] randomized bursts");
      for (int k = 0; k < 8; k++) begin
         ra  = 24'($urandom);
         len = $urandom_range(1, 3);
         rd  = $urandom;
         applyStimulus(ra, rd, len);
         qpiRead({8'($urandom), ra[15:0]}, len, $sformatf("rnd%0d", k));
         for (int i = 0; i < len; i++) begin
            idx = (int'(ra[11:0]) + i) % DEPTH;
            checkOutput($sformatf("rnd%0dByte%0d", k, i), 32'(rdBytes[i]), 32'(modelMem[idx]));
         end
      end
      for (int k = 0; k < 4; k++) begin
         idx = writtenQ[$urandom_range(0, writtenQ.size() - 1)];
         qpiRead({12'($urandom), 12'(idx)}, 1, $sformatf("rndRd%0d", k));
         checkOutput($sformatf("rndRd%0dData", k), 32'(rdBytes[0]), 32'(modelMem[idx]));
      end

      $display("[TB] reset during read wait");
      csLow();
      qpiByte(8'hEB);
      qpiAddr(24'h00AAAA);
      sclkCycle(4'h0);
      sclkCycle(4'h0);
      sclkCycle(4'h0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midRstOe", 32'(oSioOe), 32'd0);
      checkOutput("midRstQpi", 32'(oQpiMode), 32'd0);
      checkOutput("midRstBusy", 32'(oBusy), 32'd0);
      reset = 1'b0;
      csHigh(1'b0);
      csLow();
      spiByte(8'h35);
      csHigh(1'b0);
      checkOutput("reEnQpi", 32'(oQpiMode), 32'd1);
      qpiRead(24'h00AAAA, 1, "afterRst");
      checkOutput("afterRstData", 32'(rdBytes[0]), 32'(modelMem[12'hAAA]));

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
